// File: rtl/pixel_sequencer.sv
// pixel_sequencer
// Walks a source image BRAM one pixel at a time, hands each pixel to the
// downstream `process` block over the OKin/OKout handshake, and writes the
// returned result into a destination BRAM at the same address.
//
// Ports:
//   clka                 system clock, rising edge
//   reset                asynchronous active-low reset
//   start                begin a frame (sampled only while idle)
//   rd_ena/rd_addr       source BRAM read port; rd_data valid one cycle later
//   Rin/Gin/Bin/OKin     pixel presented to `process`
//   Rout/Gout/Bout/OKout result returned by `process`
//   wr_ena/wr_wea/wr_addr/wr_data  destination BRAM write port
//   busy                 high from start accept until the done pulse
//   done                 one-cycle pulse after the final pixel is written
module pixel_sequencer #(
  parameter int NPIX = 90000,
  parameter int AW   = 17
) (
  input  logic          clka,
  input  logic          reset,
  input  logic          start,
  output logic          rd_ena,
  output logic [AW-1:0] rd_addr,
  input  logic [23:0]   rd_data,
  output logic [7:0]    Rin,
  output logic [7:0]    Gin,
  output logic [7:0]    Bin,
  output logic          OKin,
  input  logic [7:0]    Rout,
  input  logic [7:0]    Gout,
  input  logic [7:0]    Bout,
  input  logic          OKout,
  output logic          wr_ena,
  output logic          wr_wea,
  output logic [AW-1:0] wr_addr,
  output logic [23:0]   wr_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_LAT     = 3'd2,
    S_PRESENT = 3'd3,
    S_WRITE   = 3'd4,
    S_RELEASE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          rd_ena_q, rd_ena_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [23:0]   pix_q, pix_d;
  logic          ok_in_q, ok_in_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]   wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and next-output logic; all outputs are registered from the
  // state being entered so they line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    pix_d     = pix_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = {AW{1'b0}};
          busy_d  = 1'b1;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_LAT;
      end
      S_LAT: begin
        // BRAM data for the address issued in READ is valid now.
        pix_d   = rd_data;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (OKout) begin
          wr_data_d = {Rout, Gout, Bout};
          wr_addr_d = idx_q;
          state_d   = S_WRITE;
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_WRITE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Hold off the next pixel until `process` has dropped OKout.
        if (!OKout) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_READ;
          end
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_READ) begin
      rd_addr_d = idx_d;
    end else begin
      rd_addr_d = rd_addr_d;
    end

    rd_ena_d = (state_d == S_READ);
    ok_in_d  = (state_d == S_PRESENT);
    wr_en_d  = (state_d == S_WRITE);
  end

  // State and output registers; reset clears everything at once so a frame
  // cut short by reset never completes its pending write or pulses done.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= {AW{1'b0}};
      rd_ena_q  <= 1'b0;
      rd_addr_q <= {AW{1'b0}};
      pix_q     <= 24'h000000;
      ok_in_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_data_q <= 24'h000000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_ena_q  <= rd_ena_d;
      rd_addr_q <= rd_addr_d;
      pix_q     <= pix_d;
      ok_in_q   <= ok_in_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_ena        = rd_ena_q;
  assign rd_addr       = rd_addr_q;
  assign {Rin, Gin, Bin} = pix_q;
  assign OKin          = ok_in_q;
  assign wr_ena        = wr_en_q;
  assign wr_wea        = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_pixel_sequencer.sv
module tb_pixel_sequencer;

  localparam int NPIX = 4;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rd_ena;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data = 24'h000000;
  logic [7:0]    rin, gin, bin;
  logic          ok_in;
  logic [7:0]    rout, gout, bout;
  logic          ok_out;
  logic          wr_ena, wr_wea;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          busy, done;

  // environment state
  logic [23:0] src [NPIX];
  logic [23:0] dst [NPIX];
  int          wr_hits [NPIX];
  int          bram_writes = 0;
  int          lat = 1;
  int          rel_len = 1;
  int          proc_mode = 0;
  logic        spur = 1'b0;
  logic        model_ok = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // identity (mode 0) or brightness +20 with saturation (mode 1)
  function automatic logic [23:0] proc_f(input logic [23:0] p, input int m);
    logic [8:0]  c;
    logic [23:0] r;
    r = p;
    if (m != 0) begin
      for (int k = 0; k < 3; k++) begin
        c = {1'b0, p[k*8 +: 8]} + 9'd20;
        r[k*8 +: 8] = c[8] ? 8'hFF : c[7:0];
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({rd_ena, rd_addr, rin, gin, bin, ok_in, wr_ena, wr_wea,
                wr_addr, wr_data, busy, done});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  assign {rout, gout, bout} = proc_f({rin, gin, bin}, proc_mode);
  assign ok_out = model_ok | spur;

  pixel_sequencer #(.NPIX(NPIX), .AW(AW)) dut (
    .clka(clk), .reset(reset), .start(start),
    .rd_ena(rd_ena), .rd_addr(rd_addr), .rd_data(rd_data),
    .Rin(rin), .Gin(gin), .Bin(bin), .OKin(ok_in),
    .Rout(rout), .Gout(gout), .Bout(bout), .OKout(ok_out),
    .wr_ena(wr_ena), .wr_wea(wr_wea), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  // source and destination BRAMs
  always @(posedge clk) begin
    if (rd_ena) rd_data <= src[rd_addr];
    if (wr_ena && wr_wea) begin
      dst[wr_addr]     <= wr_data;
      wr_hits[wr_addr] <= wr_hits[wr_addr] + 1;
      bram_writes      <= bram_writes + 1;
    end
  end

  // reference model + `process` handshake model, evaluated mid-cycle
  int          nxt_rd = 0, nxt_wr = 0, wr_cnt = 0, gap = -1, last_rd = 0;
  int          done_cnt = 0, hi_cnt = 0, rel_cnt = 0;
  logic        in_frame = 1'b0, prev_ok = 1'b0, prev_done = 1'b0;
  logic [23:0] prev_pix = 24'h000000;

  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_outputs", outs(), 64'd0);
      nxt_rd = 0; nxt_wr = 0; wr_cnt = 0; gap = -1; last_rd = 0;
      in_frame = 1'b0; prev_ok = 1'b0; prev_done = 1'b0;
      hi_cnt = 0; rel_cnt = 0; model_ok = 1'b0;
    end else begin
      if (gap >= 0) gap++;
      if (rd_ena) begin
        chk("rd_addr", 64'(rd_addr), 64'(nxt_rd));
        chk("okout_low_before_read", 64'(model_ok), 64'd0);
        if (gap > 0) chk("pixel_cycles", 64'(gap), 64'(3 + lat + rel_len));
        gap = 0; last_rd = int'(rd_addr); nxt_rd++; in_frame = 1'b1;
      end
      if (ok_in) begin
        chk("pixel_in", 64'({rin, gin, bin}), 64'(src[last_rd]));
        if (prev_ok) chk("pixel_stable", 64'({rin, gin, bin}), 64'(prev_pix));
      end
      chk("wea_eq_ena", 64'(wr_wea), 64'(wr_ena));
      if (wr_ena) begin
        chk("wr_addr", 64'(wr_addr), 64'(nxt_wr));
        chk("wr_data", 64'(wr_data), 64'(proc_f(src[nxt_wr % NPIX], proc_mode)));
        nxt_wr++; wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk("writes_per_frame", 64'(wr_cnt), 64'(NPIX));
        chk("done_single_cycle", 64'(prev_done), 64'd0);
        nxt_rd = 0; nxt_wr = 0; wr_cnt = 0; gap = -1; in_frame = 1'b0;
      end
      chk("busy", 64'(busy), 64'(in_frame));
      prev_ok = ok_in; prev_pix = {rin, gin, bin}; prev_done = done;
      // OKout rises on the lat-th cycle of OKin, stays rel_len cycles after OKin falls
      if (ok_in) begin
        hi_cnt++; rel_cnt = 0; model_ok = (hi_cnt >= lat);
      end else if (model_ok) begin
        rel_cnt++; model_ok = (rel_cnt <= rel_len);
      end else begin
        hi_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit extra_start, input bit inject,
                           output int okin_cyc, output int cyc);
    int  spur_left;
    bit  seen_done;
    okin_cyc = 0; cyc = 0; spur_left = 0; seen_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 2000) begin
      if (ok_in) okin_cyc++;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (extra_start) start = (cyc >= 10 && cyc < 13);
      if (inject && rd_ena && rd_addr == 2'd1 && spur_left == 0) begin
        spur = 1'b1; spur_left = 2;
      end else if (spur_left > 0) begin
        spur_left--;
        if (spur_left == 0) spur = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    spur  = 1'b0;
    if (!seen_done) chk("done_timeout", 64'd0, 64'd1);
    repeat (2) tick();
  endtask

  task automatic load_basic();
    src[0] = 24'h102030; src[1] = 24'h405060;
    src[2] = 24'h708090; src[3] = 24'hA0B0C0;
  endtask

  task automatic check_basic_dst(input string tag);
    chk({tag, "_dst0"}, 64'(dst[0]), 64'h102030);
    chk({tag, "_dst1"}, 64'(dst[1]), 64'h405060);
    chk({tag, "_dst2"}, 64'(dst[2]), 64'h708090);
    chk({tag, "_dst3"}, 64'(dst[3]), 64'hA0B0C0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc, cy, w0, d0, h2;
    bit found;
    reset = 1'b1; start = 1'b0;
    load_basic();
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rd_ena", 64'(rd_ena), 64'd0);

    // basic frame, identity, L=1 R=1
    w0 = bram_writes; d0 = done_cnt;
    run_frame(1'b0, 1'b0, oc, cy);
    chk("basic_writes", 64'(bram_writes - w0), 64'd4);
    chk("basic_done_count", 64'(done_cnt - d0), 64'd1);
    chk("basic_frame_cycles", 64'(cy), 64'd21);
    chk("basic_okin_cycles", 64'(oc), 64'd4);
    check_basic_dst("basic");

    // variable latency L=5 R=3, brightness model
    lat = 5; rel_len = 3; proc_mode = 1; src[0] = 24'hFF0000;
    w0 = bram_writes;
    run_frame(1'b0, 1'b0, oc, cy);
    chk("varlat_writes", 64'(bram_writes - w0), 64'd4);
    chk("varlat_frame_cycles", 64'(cy), 64'd45);
    chk("varlat_okin_cycles", 64'(oc), 64'd20);
    chk("varlat_dst0", 64'(dst[0]), 64'hFF1414);

    // start held high mid-frame is ignored
    lat = 1; rel_len = 1; proc_mode = 0; load_basic();
    w0 = bram_writes; d0 = done_cnt;
    run_frame(1'b1, 1'b0, oc, cy);
    chk("start_ignored_writes", 64'(bram_writes - w0), 64'd4);
    chk("start_ignored_cycles", 64'(cy), 64'd21);
    chk("start_ignored_done", 64'(done_cnt - d0), 64'd1);
    check_basic_dst("start_ignored");

    // spurious OKout during READ/LAT of pixel 1
    w0 = bram_writes;
    run_frame(1'b0, 1'b1, oc, cy);
    chk("spurious_writes", 64'(bram_writes - w0), 64'd4);
    chk("spurious_cycles", 64'(cy), 64'd21);
    check_basic_dst("spurious");

    // reset during PRESENT of pixel 2
    h2 = wr_hits[2]; d0 = done_cnt; found = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ok_in && rd_addr == 2'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("reach_present_px2", 64'(found), 64'd1);
    #2 reset = 1'b0;
    #1 chk("reset_async_outputs", outs(), 64'd0);
    repeat (2) tick();
    chk("reset_no_write_px2", 64'(wr_hits[2] - h2), 64'd0);
    chk("reset_no_done", 64'(done_cnt - d0), 64'd0);
    reset = 1'b1;
    tick();
    w0 = bram_writes;
    run_frame(1'b0, 1'b0, oc, cy);
    chk("after_reset_writes", 64'(bram_writes - w0), 64'd4);
    chk("after_reset_cycles", 64'(cy), 64'd21);
    check_basic_dst("after_reset");

    // saturating brightness, L=2 R=2
    lat = 2; rel_len = 2; proc_mode = 1;
    src[0] = 24'h00F0FF; src[1] = 24'hEBEC14;
    src[2] = 24'h010203; src[3] = 24'hA0B0C0;
    w0 = bram_writes;
    run_frame(1'b0, 1'b0, oc, cy);
    chk("sat_writes", 64'(bram_writes - w0), 64'd4);
    chk("sat_frame_cycles", 64'(cy), 64'd29);
    chk("sat_dst0", 64'(dst[0]), 64'h14FFFF);
    chk("sat_dst1", 64'(dst[1]), 64'hFFFF28);
    chk("sat_dst2", 64'(dst[2]), 64'h151617);
    chk("sat_dst3", 64'(dst[3]), 64'hB4C4D4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
